// File: rtl/simpleuart.sv
// simpleuart: 8N1 UART with a programmable bit divider and a one-byte receive buffer.
// Define SIMPLEUART_RX_EN to build the receiver; without it the block is transmit-only.
module simpleuart #(
  parameter logic [31:0] DEFAULT_DIV = 32'd1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait
);

  logic [31:0] div_q, div_d;

  logic [9:0]  tx_pattern_q, tx_pattern_d;
  logic [3:0]  tx_bitcnt_q, tx_bitcnt_d;
  logic [31:0] tx_cnt_q, tx_cnt_d;
  logic        tx_dummy_q, tx_dummy_d;
  logic        tx_busy;

  logic        unused_bits;

  always_comb begin
    div_d = div_q;
    for (int i = 0; i < 4; i++) begin
      if (reg_div_we[i]) begin
        div_d[8*i +: 8] = reg_div_di[8*i +: 8];
      end
    end
  end

  assign tx_busy      = (tx_bitcnt_q != 4'd0) || tx_dummy_q;
  assign reg_dat_wait = reg_dat_we && tx_busy;
  assign ser_tx       = tx_pattern_q[0];
  assign reg_div_do   = div_q;

  // A pending dummy frame idles the line for 15 bit times after reset or a rate change.
  always_comb begin
    tx_pattern_d = tx_pattern_q;
    tx_bitcnt_d  = tx_bitcnt_q;
    tx_cnt_d     = tx_cnt_q + 32'd1;
    tx_dummy_d   = tx_dummy_q;
    if (tx_dummy_q && (tx_bitcnt_q == 4'd0)) begin
      tx_pattern_d = '1;
      tx_bitcnt_d  = 4'd15;
      tx_cnt_d     = '0;
      tx_dummy_d   = 1'b0;
    end else if (reg_dat_we && (tx_bitcnt_q == 4'd0)) begin
      tx_pattern_d = {1'b1, reg_dat_di[7:0], 1'b0};
      tx_bitcnt_d  = 4'd10;
      tx_cnt_d     = '0;
    end else if ((tx_bitcnt_q != 4'd0) && (tx_cnt_q > div_q)) begin
      tx_pattern_d = {1'b1, tx_pattern_q[9:1]};
      tx_bitcnt_d  = tx_bitcnt_q - 4'd1;
      tx_cnt_d     = '0;
    end
    if (reg_div_we != 4'd0) begin
      tx_dummy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q        <= DEFAULT_DIV;
      tx_pattern_q <= '1;
      tx_bitcnt_q  <= '0;
      tx_cnt_q     <= '0;
      tx_dummy_q   <= 1'b1;
    end else begin
      div_q        <= div_d;
      tx_pattern_q <= tx_pattern_d;
      tx_bitcnt_q  <= tx_bitcnt_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_dummy_q   <= tx_dummy_d;
    end
  end

`ifdef SIMPLEUART_RX_EN
  typedef enum logic [3:0] {
    RX_IDLE, RX_HALF,
    RX_BIT0, RX_BIT1, RX_BIT2, RX_BIT3,
    RX_BIT4, RX_BIT5, RX_BIT6, RX_BIT7,
    RX_STOP
  } rx_state_t;

  rx_state_t   rx_state_q, rx_state_d;
  logic [31:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_pattern_q, rx_pattern_d;
  logic [7:0]  rx_buf_q, rx_buf_d;
  logic        rx_valid_q, rx_valid_d;

  // HALF waits about half a bit so each data bit is sampled near its middle.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + 32'd1;
    rx_pattern_d = rx_pattern_q;
    rx_buf_d     = rx_buf_q;
    rx_valid_d   = rx_valid_q && !reg_dat_re;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!ser_rx) begin
          rx_state_d = RX_HALF;
        end
      end
      RX_HALF: begin
        if ({rx_cnt_q, 1'b0} > {1'b0, div_q}) begin
          rx_state_d = RX_BIT0;
          rx_cnt_d   = '0;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q > div_q) begin
          rx_buf_d   = rx_pattern_q;
          rx_valid_d = 1'b1;
          rx_state_d = RX_IDLE;
          rx_cnt_d   = '0;
        end
      end
      default: begin
        if (rx_cnt_q > div_q) begin
          rx_pattern_d = {ser_rx, rx_pattern_q[7:1]};
          rx_state_d   = rx_state_t'(rx_state_q + 4'd1);
          rx_cnt_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_pattern_q <= '0;
      rx_buf_q     <= '0;
      rx_valid_q   <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_pattern_q <= rx_pattern_d;
      rx_buf_q     <= rx_buf_d;
      rx_valid_q   <= rx_valid_d;
    end
  end

  assign reg_dat_do  = rx_valid_q ? {24'd0, rx_buf_q} : 32'hFFFF_FFFF;
  assign unused_bits = &{1'b0, reg_dat_di[31:8]};
`else
  assign reg_dat_do  = 32'hFFFF_FFFF;
  assign unused_bits = &{1'b0, ser_rx, reg_dat_re, reg_dat_di[31:8]};
`endif

endmodule

// File: tb/tb_simpleuart.sv
// Bench for simpleuart: random TX/RX traffic checked every cycle against a bit-run model.
`timescale 1ns/1ps
module tb_simpleuart;

  localparam logic [31:0] DEFAULT_DIV = 32'd1;
`ifdef SIMPLEUART_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ser_tx;
  logic        ser_rx = 1'b1;
  logic [3:0]  reg_div_we = 4'd0;
  logic [31:0] reg_div_di = 32'd0;
  logic [31:0] reg_div_do;
  logic        reg_dat_we = 1'b0;
  logic        reg_dat_re = 1'b0;
  logic [31:0] reg_dat_di = 32'd0;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  simpleuart #(.DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk(clk), .resetn(resetn), .ser_tx(ser_tx), .ser_rx(ser_rx),
    .reg_div_we(reg_div_we), .reg_div_di(reg_div_di), .reg_div_do(reg_div_do),
    .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re), .reg_dat_di(reg_dat_di),
    .reg_dat_do(reg_dat_do), .reg_dat_wait(reg_dat_wait)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;

  // Reference model: the line is a list of (level, duration) runs, one per bit time.
  typedef struct { logic lvl; longint unsigned cycles; } run_t;
  typedef struct { longint unsigned doneEdge; logic [7:0] data; } rx_evt_t;

  run_t            txRuns[$];
  rx_evt_t         rxEvts[$];
  logic [31:0]     mDiv = DEFAULT_DIV;
  logic            mDummy = 1'b1;
  logic            mTxLevel = 1'b1;
  logic            mRxValid = 1'b0;
  logic [7:0]      mRxBuf = 8'd0;
  longint unsigned edgeCount = 0;
  bit              modelLive = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic boundExpired(input string name, input int limit);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: still waiting after %0d cycles, want completion", name, limit);
  endtask

  always @(posedge clk) begin
    logic            txIdle;
    logic [9:0]      frame;
    longint unsigned bitLen;
    edgeCount++;
    if (!resetn) begin
      mDiv = DEFAULT_DIV;
      txRuns.delete();
      rxEvts.delete();
      mDummy = 1'b1;
      mTxLevel = 1'b1;
      mRxValid = 1'b0;
      mRxBuf = 8'd0;
      modelLive = 1'b1;
    end else if (modelLive) begin
      for (int i = 0; i < 4; i++)
        if (reg_div_we[i]) mDiv[8*i +: 8] = reg_div_di[8*i +: 8];
      bitLen = longint'(mDiv) + 64'd2;
      txIdle = (txRuns.size() == 0);
      if (txIdle && mDummy) begin
        for (int b = 0; b < 15; b++) txRuns.push_back('{lvl: 1'b1, cycles: bitLen});
        txRuns.push_back('{lvl: 1'b1, cycles: 64'd1});
        mDummy = 1'b0;
      end else if (txIdle && reg_dat_we) begin
        frame = {1'b1, reg_dat_di[7:0], 1'b0};
        for (int b = 0; b < 10; b++) txRuns.push_back('{lvl: frame[b], cycles: bitLen});
        txRuns.push_back('{lvl: 1'b1, cycles: 64'd1});
      end
      if (reg_div_we != 4'd0) mDummy = 1'b1;
      if (txRuns.size() != 0) begin
        mTxLevel = txRuns[0].lvl;
        if (txRuns[0].cycles <= 64'd1) void'(txRuns.pop_front());
        else txRuns[0].cycles = txRuns[0].cycles - 64'd1;
      end else begin
        mTxLevel = 1'b1;
      end
      if (rxEvts.size() != 0 && rxEvts[0].doneEdge == edgeCount) begin
        mRxValid = 1'b1;
        mRxBuf = rxEvts[0].data;
        void'(rxEvts.pop_front());
      end else if (reg_dat_re) begin
        mRxValid = 1'b0;
      end
    end
  end

  // Every cycle after the first reset edge, all outputs are compared to the model.
  always @(negedge clk) begin
    logic [31:0] expDo;
    logic        expWait;
    #2;
    if (modelLive) begin
      expDo = (RX_EN && mRxValid) ? {24'd0, mRxBuf} : 32'hFFFF_FFFF;
      expWait = reg_dat_we && ((txRuns.size() != 0) || mDummy);
      checkOutput("ser_tx", 32'(ser_tx), 32'(mTxLevel));
      checkOutput("reg_dat_wait", 32'(reg_dat_wait), 32'(expWait));
      checkOutput("reg_div_do", reg_div_do, mDiv);
      checkOutput("reg_dat_do", reg_dat_do, expDo);
    end
  end

  task automatic doReset(input int n);
    @(negedge clk);
    resetn = 1'b0;
    repeat (n) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic waitTxIdle(input int limit);
    int k = 0;
    while (((txRuns.size() != 0) || mDummy) && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (k >= limit) boundExpired("tx_idle_wait", limit);
  endtask

  task automatic writeDiv(input logic [3:0] mask, input logic [31:0] data);
    @(negedge clk);
    reg_div_we = mask;
    reg_div_di = data;
    @(negedge clk);
    reg_div_we = 4'd0;
  endtask

  // Holds the request until wait drops, then releases it one cycle later.
  task automatic sendTx(input logic [7:0] b, output int waitHigh);
    logic [31:0] r;
    int k = 0;
    waitHigh = 0;
    r = $urandom();
    @(negedge clk);
    reg_dat_we = 1'b1;
    reg_dat_di = {r[31:8], b};
    #1;
    while (reg_dat_wait && k < 5000) begin
      waitHigh++;
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 5000) boundExpired("tx_accept_wait", 5000);
    @(negedge clk);
    reg_dat_we = 1'b0;
  endtask

  // The byte is visible once the stop bit is sampled: detection edge, half a bit, then 9 bit times.
  task automatic sendRx(input logic [7:0] b);
    logic [9:0] frame;
    longint unsigned bitLen;
    frame = {1'b1, b, 1'b0};
    bitLen = longint'(mDiv) + 64'd2;
    @(negedge clk);
    rxEvts.push_back('{doneEdge: edgeCount + 64'd1 + (longint'(mDiv) / 64'd2 + 64'd1) + 64'd1 + 64'd9 * bitLen,
                       data: b});
    for (int i = 0; i < 10; i++) begin
      ser_rx = frame[i];
      repeat (int'(bitLen)) @(negedge clk);
    end
    ser_rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic applyStimulus(input int round);
    logic [31:0] r;
    int waitHigh;
    bit rxDone;
    waitTxIdle(5000);
    for (int i = 0; i < 3; i++) begin
      r = $urandom();
      writeDiv(4'($urandom_range(1, 15)), r);
    end
    doReset(2);
    waitTxIdle(500);
    writeDiv(4'hF, 32'($urandom_range(1, 6)));
    waitTxIdle(500);
    rxDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          r = $urandom();
          sendTx(r[7:0], waitHigh);
        end
      end
      begin
        for (int j = 0; j < 3; j++) begin
          r = $urandom();
          sendRx(r[7:0]);
        end
        rxDone = 1'b1;
      end
      begin
        while (!rxDone) begin
          @(negedge clk);
          reg_dat_re = ($urandom_range(0, 5) == 0);
        end
        reg_dat_re = 1'b0;
      end
    join
    if (round % 2 == 0) begin
      r = $urandom();
      sendTx(r[7:0], waitHigh);
      repeat ($urandom_range(5, 30)) @(negedge clk);
      doReset(1);
    end
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation still running after 100000 cycles, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waitHigh;
    logic [9:0] exp55;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_div", reg_div_do, 32'd1);
    checkOutput("reset_ser_tx", 32'(ser_tx), 32'd1);
    checkOutput("reset_dat_do", reg_dat_do, 32'hFFFF_FFFF);
    resetn = 1'b1;
    waitTxIdle(500);

    writeDiv(4'b0001, 32'h0000_0004);
    writeDiv(4'b0010, 32'h0000_AB00);
    #1;
    checkOutput("div_lane_write", reg_div_do, 32'h0000_AB04);
    doReset(2);
    waitTxIdle(500);

    writeDiv(4'hF, 32'd4);
    sendTx(8'h55, waitHigh);
    checkOutput("dummy_wait_cycles", 32'(waitHigh), 32'd90);
    exp55 = 10'b1010101010;
    for (int n = 0; n < 10; n++) begin
      repeat (3) @(negedge clk);
      #1;
      checkOutput("tx55_bit", 32'(ser_tx), 32'(exp55[n]));
      repeat (3) @(negedge clk);
    end
    waitTxIdle(500);

    sendRx(8'hA3);
    #1;
    checkOutput("rx_a3", reg_dat_do, RX_EN ? 32'h0000_00A3 : 32'hFFFF_FFFF);
    sendRx(8'h0F);
    #1;
    checkOutput("rx_overwrite_0f", reg_dat_do, RX_EN ? 32'h0000_000F : 32'hFFFF_FFFF);
    @(negedge clk);
    reg_dat_re = 1'b1;
    @(negedge clk);
    reg_dat_re = 1'b0;
    #1;
    checkOutput("rx_read_clears", reg_dat_do, 32'hFFFF_FFFF);

    for (int round = 0; round < 6; round++) applyStimulus(round);
    waitTxIdle(5000);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/simpleuart.md
SIMPLEUART -- requirements
Module: simpleuart

Interface
REQ-001 Parameter DEFAULT_DIV, default 1; divider value loaded at reset.
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 ser_tx  out  1  serial transmit line, idle high.
REQ-005 ser_rx  in  1  serial receive line, idle high.
REQ-006 reg_div_we  in  4  byte write enables for divider register, bit n covers bits [8n+7:8n].
REQ-007 reg_div_di  in  32  divider write data.
REQ-008 reg_div_do  out  32  current divider value.
REQ-009 reg_dat_we  in  1  transmit request, level held by host until reg_dat_wait low.
REQ-010 reg_dat_re  in  1  receive acknowledge, clears received-byte valid flag.
REQ-011 reg_dat_di  in  32  transmit data, bits [7:0] used.
REQ-012 reg_dat_do  out  32  received byte, or all ones when none valid.
REQ-013 reg_dat_wait  out  1  combinational: reg_dat_we high and transmitter busy (bit count nonzero or dummy pending).

Function
REQ-014 Divider register: each byte lane with reg_div_we bit set loads the matching byte of reg_div_di on the clock edge; other lanes hold.
REQ-015 Bit timing (TX and RX): counter increments every clock; a bit step happens when counter > divider, then counter clears; one bit = divider+2 clocks.
REQ-016 Frame: 8N1, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-017 TX: 10-bit shift pattern, ser_tx = pattern[0]; idle pattern all ones; bit count 0 means idle.
REQ-018 TX load: reg_dat_we high, bit count 0, no dummy pending -> pattern = {1, data[7:0], 0}, bit count 10, counter 0; reg_dat_wait low that same cycle, so host drops reg_dat_we next cycle.
REQ-019 TX shift: bit count nonzero and counter > divider -> pattern shifts right filling 1, bit count decrements.
REQ-020 Dummy: any divider write sets dummy pending; when TX idle, dummy loads all-ones pattern with bit count 15 (15 idle bit times), clears dummy; dummy has priority over reg_dat_we.
REQ-021 RX state machine states: IDLE, HALF, BIT0..BIT7, STOP.
REQ-022 IDLE: ser_rx low -> HALF, counter 0.
REQ-023 HALF: when 2*counter > divider -> BIT0, counter 0 (mid-bit alignment; no start-bit revalidation).
REQ-024 BITn: counter > divider -> pattern = {ser_rx, pattern[7:1]}, next state, counter 0.
REQ-025 STOP: counter > divider -> buffer = pattern, valid = 1, IDLE; stop bit level not checked, no framing error.
REQ-026 reg_dat_do = {24'b0, buffer} when valid, else 32'hFFFFFFFF.
REQ-027 reg_dat_re high clears valid; a byte completing in the same cycle wins (valid = 1, new data).
REQ-028 New byte over an unread valid byte overwrites buffer; no overrun flag.
REQ-029 Divider change mid-frame takes effect immediately on both counters.

Reset
REQ-030 resetn low at clock edge: divider = DEFAULT_DIV, TX pattern all ones (ser_tx = 1), TX bit count 0, TX counter 0, dummy pending = 1, RX state IDLE, RX counter 0, RX pattern 0, buffer 0, valid 0.
REQ-031 After reset, reg_dat_do = 32'hFFFFFFFF, reg_div_do = DEFAULT_DIV, and the first 15 bit times are dummy idle; reset mid-frame aborts both directions at once.

Configuration
REQ-032 Macro SIMPLEUART_RX_EN defined: receiver per REQ-021..028 present.
REQ-033 SIMPLEUART_RX_EN undefined: no receiver logic; ser_rx ignored; reg_dat_re ignored; reg_dat_do constant 32'hFFFFFFFF; TX and divider unchanged.

Verification
REQ-034 Reset, DEFAULT_DIV=1 -> reg_div_do=1, ser_tx=1, reg_dat_do=32'hFFFFFFFF.
REQ-035 Write div 4 with reg_div_we=4'b0001 then 4'b0010 with data 32'h0000AB00 -> reg_div_do=32'h0000AB04.
REQ-036 div=4, hold reg_dat_we with data 8'h55 -> wait high through 15 dummy bits (90 clocks), then ser_tx shows 0,1,0,1,0,1,0,1,0,1, each 6 clocks.
REQ-037 div=4, drive ser_rx frame for 8'hA3 at 6 clocks/bit -> after stop bit reg_dat_do=32'h000000A3; pulse reg_dat_re -> 32'hFFFFFFFF.
REQ-038 Second frame 8'h0F without read -> reg_dat_do=32'h0000000F (overwrite).
REQ-039 SIMPLEUART_RX_EN undefined, same RX stimulus -> reg_dat_do stays 32'hFFFFFFFF.
